// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared states, control/flag bit map and atan table for the CORDIC sequencer
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITERATE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int unsigned ITER_W = 5;

  localparam int unsigned CTL_START       = 0;
  localparam int unsigned CTL_STOP        = 1;
  localparam int unsigned CTL_MODE        = 2;
  localparam int unsigned CTL_SYSTEM      = 3;
  localparam int unsigned CTL_ERR_IRQ_EN  = 4;
  localparam int unsigned CTL_RES_IRQ_EN  = 5;
  localparam int unsigned CTL_XY_OVF_STOP = 6;
  localparam int unsigned CTL_Z_OVF_STOP  = 7;
  localparam int unsigned CTL_N_LSB       = 8;
  localparam int unsigned CTL_N_MSB       = 12;

  localparam int unsigned FLG_READY        = 16;
  localparam int unsigned FLG_ERROR        = 17;
  localparam int unsigned FLG_INPUT_ERR    = 18;
  localparam int unsigned FLG_OVF_ERR      = 19;
  localparam int unsigned FLG_X_OVF        = 20;
  localparam int unsigned FLG_Y_OVF        = 21;
  localparam int unsigned FLG_Z_OVF        = 22;
  localparam int unsigned FLG_ELAPSED_LSB  = 23;
  localparam int unsigned FLG_ELAPSED_MSB  = 27;
  localparam int unsigned FLG_OVF_ITER_LSB = 28;
  localparam int unsigned FLG_OVF_ITER_MSB = 31;

  // atan(2^-i) with 2^31 = pi; the last slot is padding, never selected
  localparam logic [31:0] ATAN32 [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Binary angle scaled so 2^63 = pi; beyond the table atan(2^-i) equals 2^-i to full precision
  function automatic logic [63:0] atan_angle(input logic [5:0] i);
    if (i <= 6'd30) begin
      return {ATAN32[i[4:0]], 32'h0};
    end
    return 64'h517C_C1B7_2722_0A94 >> ({1'b0, i} + 7'd1);
  endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// rtl/cordic_microrotation.sv - one combinational CORDIC micro-rotation with signed overflow detection
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32
) (
  input  logic signed [p_WIDTH-1:0] x,
  input  logic signed [p_WIDTH-1:0] y,
  input  logic signed [p_WIDTH-1:0] z,
  input  logic        [ITER_W-1:0]  i,
  input  logic                      mode,
  input  logic                      system,
  output logic signed [p_WIDTH-1:0] x_next,
  output logic signed [p_WIDTH-1:0] y_next,
  output logic signed [p_WIDTH-1:0] z_next,
  output logic                      x_ovf,
  output logic                      y_ovf,
  output logic                      z_ovf
);

  localparam logic [p_WIDTH-1:0] LIN_ONE = {2'b01, {(p_WIDTH-2){1'b0}}};

  // Returns {overflow, result}; overflow when effective operand signs agree and the result sign differs
  function automatic logic [p_WIDTH:0] add_sub(input logic [p_WIDTH-1:0] a,
                                               input logic [p_WIDTH-1:0] b,
                                               input logic               sub);
    logic [p_WIDTH-1:0] r;
    logic               same;
    r    = sub ? a - b : a + b;
    same = sub ? (a[p_WIDTH-1] != b[p_WIDTH-1]) : (a[p_WIDTH-1] == b[p_WIDTH-1]);
    return {same && (r[p_WIDTH-1] != a[p_WIDTH-1]), r};
  endfunction

  logic signed [p_WIDTH-1:0] x_shift;
  logic signed [p_WIDTH-1:0] y_shift;
  logic        [p_WIDTH-1:0] z_step;
  logic        [63:0]        ang64;
  logic                      d_pos;
  logic        [p_WIDTH:0]   x_sum;
  logic        [p_WIDTH:0]   y_sum;
  logic        [p_WIDTH:0]   z_sum;

  always_comb begin
    x_shift = x >>> i;
    y_shift = y >>> i;
    ang64   = atan_angle({1'b0, i});
    z_step  = system ? (LIN_ONE >> i) : p_WIDTH'(ang64 >> (64 - p_WIDTH));
    d_pos   = mode ? y[p_WIDTH-1] : ~z[p_WIDTH-1];
    x_sum   = add_sub(x, y_shift, d_pos);
    y_sum   = add_sub(y, x_shift, ~d_pos);
    z_sum   = add_sub(z, z_step, d_pos);
    x_next  = system ? x : x_sum[p_WIDTH-1:0];
    x_ovf   = ~system & x_sum[p_WIDTH];
    y_next  = y_sum[p_WIDTH-1:0];
    y_ovf   = y_sum[p_WIDTH];
    z_next  = z_sum[p_WIDTH-1:0];
    z_ovf   = z_sum[p_WIDTH];
  end

endmodule

// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - CORDIC engine controller: FSM, iteration counter, flags and bus writeback
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [p_WIDTH-1:0] xInput,
  input  logic signed [p_WIDTH-1:0] yInput,
  input  logic signed [p_WIDTH-1:0] zInput,
  input  logic        [p_WIDTH-1:0] controlRegisterInput,
  output logic signed [p_WIDTH-1:0] xResult,
  output logic signed [p_WIDTH-1:0] yResult,
  output logic signed [p_WIDTH-1:0] zResult,
  output logic        [p_WIDTH-1:0] controlRegisterOutput,
  output logic                      controlRegisterWriteEnable,
  output logic                      interrupt
);

  localparam logic [p_WIDTH-1:0] CR_RESET = {{(p_WIDTH-17){1'b0}}, 1'b1, 16'h0};

  state_e                    state_q, state_d;
  logic signed [p_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic        [p_WIDTH-1:0] cr_q, cr_d;
  logic        [ITER_W-1:0]  i_q, i_d;
  logic                      we_q, we_d, irq_q, irq_d;

  logic signed [p_WIDTH-1:0] x_nx, y_nx, z_nx;
  logic                      x_ovf, y_ovf, z_ovf;
  logic        [ITER_W-1:0]  n_in, n_q;
  logic                      start_err, ovf_stop, unused_ctl_bits;

  cordic_microrotation #(.p_WIDTH(p_WIDTH)) u_rot (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .i      (i_q),
    .mode   (cr_q[CTL_MODE]),
    .system (cr_q[CTL_SYSTEM]),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx),
    .x_ovf  (x_ovf),
    .y_ovf  (y_ovf),
    .z_ovf  (z_ovf)
  );

  assign n_in            = controlRegisterInput[CTL_N_MSB:CTL_N_LSB];
  assign n_q             = cr_q[CTL_N_MSB:CTL_N_LSB];
  assign start_err       = (n_in == '0) || (int'(n_in) > p_WIDTH - 2) || controlRegisterInput[CTL_STOP];
  assign ovf_stop        = (cr_q[CTL_XY_OVF_STOP] & (x_ovf | y_ovf)) | (cr_q[CTL_Z_OVF_STOP] & z_ovf);
  assign unused_ctl_bits = ^controlRegisterInput[p_WIDTH-1:CTL_N_MSB+1];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cr_d    = cr_q;
    i_d     = i_q;
    we_d    = 1'b0;
    irq_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (controlRegisterInput[CTL_START]) begin
          // Start/stop never appear in the written-back word, so the bus cannot re-trigger
          cr_d                     = '0;
          cr_d[CTL_N_MSB:CTL_MODE] = controlRegisterInput[CTL_N_MSB:CTL_MODE];
          we_d                     = 1'b1;
          if (start_err) begin
            state_d            = ST_ERROR;
            cr_d[FLG_READY]     = 1'b1;
            cr_d[FLG_ERROR]     = 1'b1;
            cr_d[FLG_INPUT_ERR] = 1'b1;
            irq_d               = controlRegisterInput[CTL_ERR_IRQ_EN];
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        x_d     = xInput;
        y_d     = yInput;
        z_d     = zInput;
        i_d     = '0;
        state_d = ST_ITERATE;
      end
      ST_ITERATE: begin
        if (controlRegisterInput[CTL_STOP]) begin
          state_d         = ST_IDLE;
          cr_d[FLG_READY] = 1'b1;
          we_d            = 1'b1;
        end else begin
          x_d = x_nx;
          y_d = y_nx;
          z_d = z_nx;
          i_d = i_q + 1'b1;
          cr_d[FLG_ELAPSED_MSB:FLG_ELAPSED_LSB] = i_q + 1'b1;
          cr_d[FLG_X_OVF] = cr_q[FLG_X_OVF] | x_ovf;
          cr_d[FLG_Y_OVF] = cr_q[FLG_Y_OVF] | y_ovf;
          cr_d[FLG_Z_OVF] = cr_q[FLG_Z_OVF] | z_ovf;
          if ((x_ovf | y_ovf | z_ovf) && !(|cr_q[FLG_Z_OVF:FLG_X_OVF])) begin
            cr_d[FLG_OVF_ITER_MSB:FLG_OVF_ITER_LSB] = (i_q > 5'd15) ? 4'hF : i_q[3:0];
          end
          if (ovf_stop || (i_q == n_q - 1'b1)) begin
            state_d           = ST_DONE;
            cr_d[FLG_READY]   = 1'b1;
            cr_d[FLG_OVF_ERR] = ovf_stop;
            cr_d[FLG_ERROR]   = ovf_stop;
            we_d              = 1'b1;
            irq_d             = ovf_stop ? cr_q[CTL_ERR_IRQ_EN] : cr_q[CTL_RES_IRQ_EN];
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cr_q    <= CR_RESET;
      i_q     <= '0;
      we_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cr_q    <= cr_d;
      i_q     <= i_d;
      we_q    <= we_d;
      irq_q   <= irq_d;
    end
  end

  assign xResult                    = x_q;
  assign yResult                    = y_q;
  assign zResult                    = z_q;
  assign controlRegisterOutput      = cr_q;
  assign controlRegisterWriteEnable = we_q;
  assign interrupt                  = irq_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb/tb_cordic_sequencer.sv - scoreboard bench for cordic_sequencer with a modelled bus control register
module tb_cordic_sequencer;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] cr;
    logic        irq;
    bit          chk;
    logic [31:0] x, y, z, tx, ty, tz;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] x_in, y_in, z_in;
  logic        [31:0] ctrl_reg = '0;
  logic signed [31:0] x_res, y_res, z_res;
  logic        [31:0] cr_out;
  logic               cr_we, irq;
  logic               sw_wr;
  logic        [31:0] sw_data;
  int                 cyc = 0;
  int                 start_cyc;
  int                 checks;
  int                 errors;
  exp_t               sb[$];

  always #5 clk = ~clk;

  cordic_sequencer #(.p_WIDTH(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .xInput                     (x_in),
    .yInput                     (y_in),
    .zInput                     (z_in),
    .controlRegisterInput       (ctrl_reg),
    .xResult                    (x_res),
    .yResult                    (y_res),
    .zResult                    (z_res),
    .controlRegisterOutput      (cr_out),
    .controlRegisterWriteEnable (cr_we),
    .interrupt                  (irq)
  );

  // Bus side: software writes win, otherwise the engine's writeback is stored
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sw_wr) ctrl_reg <= sw_data;
    else if (cr_we) ctrl_reg <= cr_out;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tol_pick(input logic [31:0] act, input logic [31:0] exp,
                                           input logic [31:0] tol);
    logic signed [32:0] d;
    d = $signed({act[31], act}) - $signed({exp[31], exp});
    if (d < 0) d = -d;
    return (d <= $signed({1'b0, tol})) ? exp : act;
  endfunction

  task automatic push_exp(input string name, input int c, input logic [31:0] cr, input logic ir,
                          input bit chk, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] tx, input logic [31:0] ty,
                          input logic [31:0] tz);
    exp_t e;
    e.name = name; e.cyc = c; e.cr = cr; e.irq = ir; e.chk = chk;
    e.x = x; e.y = y; e.z = z; e.tx = tx; e.ty = ty; e.tz = tz;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cr_we) begin
      if (sb.size() == 0) begin
        check_eq("we_unexpected", {63'b0, cr_we}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq({e.name, "_cyc"}, 64'(cyc - start_cyc), 64'(e.cyc));
        check_eq({e.name, "_cr"}, {32'b0, cr_out}, {32'b0, e.cr});
        check_eq({e.name, "_irq"}, {63'b0, irq}, {63'b0, e.irq});
        if (e.chk) begin
          check_eq({e.name, "_x"}, {32'b0, tol_pick(x_res, e.x, e.tx)}, {32'b0, e.x});
          check_eq({e.name, "_y"}, {32'b0, tol_pick(y_res, e.y, e.ty)}, {32'b0, e.y});
          check_eq({e.name, "_z"}, {32'b0, tol_pick(z_res, e.z, e.tz)}, {32'b0, e.z});
        end
      end
    end
    if (!rst && irq && !cr_we) check_eq("irq_stray", {63'b0, irq}, 64'd0);
  end

  task automatic bus_write(input logic [31:0] v, input bit is_start);
    sw_data = v;
    sw_wr   = 1'b1;
    @(negedge clk);
    sw_wr = 1'b0;
    if (is_start) start_cyc = cyc;
  endtask

  task automatic run_start(input logic [31:0] ctrl, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
    x_in = x; y_in = y; z_in = z;
    bus_write(ctrl, 1'b1);
  endtask

  task automatic wait_cycle(input int k);
    while (cyc - start_cyc < k) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_x"}, {32'b0, x_res}, 64'd0);
    check_eq({tag, "_y"}, {32'b0, y_res}, 64'd0);
    check_eq({tag, "_z"}, {32'b0, z_res}, 64'd0);
    check_eq({tag, "_cr"}, {32'b0, cr_out}, 64'h0001_0000);
    check_eq({tag, "_we"}, {63'b0, cr_we}, 64'd0);
    check_eq({tag, "_irq"}, {63'b0, irq}, 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; start_cyc = 0;
    rst = 1'b1; sw_wr = 1'b0; sw_data = '0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Rejected starts: N=0, N above p_WIDTH-2, start together with stop
    push_exp("inerr_n0", 1, 32'h0007_0010, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
    run_start(32'h0000_0011, 32'h1234_5678, 32'h0765_4321, 32'h0111_1111);
    wait_drain(10);
    push_exp("inerr_nbig", 1, 32'h0007_1F20, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    run_start(32'h0000_1F21, 32'h1234_5678, 32'h0765_4321, 32'h0111_1111);
    wait_drain(10);
    push_exp("inerr_stop", 1, 32'h0007_0510, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
    run_start(32'h0000_0513, 32'h1234_5678, 32'h0765_4321, 32'h0111_1111);
    wait_drain(10);

    // Linear rotation: y = x*z = 1.0*0.5
    push_exp("lin_load", 1, 32'h0000_1028, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    push_exp("lin_done", 18, 32'h0801_1028, 1'b1, 1'b1,
             32'h4000_0000, 32'h2000_0000, 32'h0, 32'h0, 32'h8000, 32'h8000);
    run_start(32'h0000_1029, 32'h4000_0000, 32'h0, 32'h2000_0000);
    wait_drain(40);

    // Circular rotation by pi/4 of 0.5 including CORDIC gain
    push_exp("circ_load", 1, 32'h0000_1820, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    push_exp("circ_done", 26, 32'h0C01_1820, 1'b1, 1'b1,
             32'h2543_0000, 32'h2543_0000, 32'h0, 32'h1_0000, 32'h1_0000, 32'h100);
    run_start(32'h0000_1821, 32'h2000_0000, 32'h0, 32'h2000_0000);
    wait_drain(50);

    // Circular vectoring overflow on x at iteration 0 with stop enabled
    push_exp("ovf_load", 1, 32'h0000_0A54, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    push_exp("ovf_done", 3, 32'h009B_0A54, 1'b1, 1'b1,
             32'hE000_0000, 32'h0, 32'h2000_0000, 32'h0, 32'h0, 32'h0);
    run_start(32'h0000_0A55, 32'h7000_0000, 32'h7000_0000, 32'h0);
    wait_drain(20);

    // Abort: stop visible during the sixth ITERATE cycle
    push_exp("abort_load", 1, 32'h0000_1430, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    push_exp("abort_stop", 8, 32'h0281_1430, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    run_start(32'h0000_1431, 32'h2000_0000, 32'h0, 32'h1000_0000);
    wait_cycle(6);
    bus_write(ctrl_reg | 32'h2, 1'b0);
    wait_drain(40);

    // Reset in the middle of a second run
    push_exp("rerun_load", 1, 32'h0000_1430, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    run_start(32'h0000_1431, 32'h2000_0000, 32'h0, 32'h1000_0000);
    wait_cycle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    check_eq("midrst_sb", 64'(sb.size()), 64'd0);
    repeat (30) @(negedge clk);
    check_eq("midrst_idle_cr", {32'b0, cr_out}, 64'h0001_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
